// File: rtl/mem_access_stage_if.sv
// Memory-side handshake bundle for mem_access_stage: request/write-enable/address/data out,
// ack/read data back.
interface mem_access_stage_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: multi-cycle memory access FSM with pipeline stall and MEM/WB register.
// Optional access timeout/abort enabled by defining MEM_TIMEOUT_EN.
module mem_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       RegWriteIn,
  input  logic                       MemtoRegIn,
  input  logic                       MemWriteIn,
  input  logic                       MemReadIn,
  input  logic                       BranchIn,
  input  logic                       ZeroIn,
  input  logic [31:0]                ALUResultIn,
  input  logic [31:0]                WriteDataIn,
  input  logic [4:0]                 WriteRegIn,
  input  logic [7:0]                 BranchTargetIn,
  mem_access_stage_if.master         mem,
  output logic                       stall,
  output logic                       PCSrc,
  output logic [7:0]                 BranchTargetOut,
  output logic                       RegWriteOut,
  output logic                       MemtoRegOut,
  output logic [31:0]                ReadDataOut,
  output logic [31:0]                ALUResultOut,
  output logic [4:0]                 WriteRegOut,
  output logic                       mem_error
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state, state_next;
  logic        mem_op;
  logic        done;
  logic        abort;
  logic        stall_c;
  logic        req_c;

  logic        lat_we;
  logic        lat_rw;
  logic        lat_m2r;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [4:0]  lat_wreg;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be nonzero");
  end

  assign mem_op = MemReadIn | MemWriteIn;
  assign done   = (state == ACCESS) && mem.mem_ack;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Abort fires in the TIMEOUT_CYCLES-th unacknowledged ACCESS cycle.
  assign abort = (state == ACCESS) && !mem.mem_ack && (cnt == TLAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      mem_error <= 1'b0;
    end else begin
      mem_error <= abort;
      if (state == ACCESS && !mem.mem_ack && !abort)
        cnt <= cnt + 1'b1;
      else
        cnt <= '0;
    end
  end
`else
  assign abort     = 1'b0;
  assign mem_error = 1'b0;
`endif

  always_comb begin
    state_next = state;
    stall_c    = 1'b0;
    req_c      = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op) begin
          state_next = ACCESS;
          stall_c    = 1'b1;
        end
      end
      ACCESS: begin
        req_c = 1'b1;
        if (mem.mem_ack || abort)
          state_next = IDLE;
        else
          stall_c = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  assign stall           = stall_c & ~reset;
  assign PCSrc           = BranchIn & ZeroIn & ~stall;
  assign BranchTargetOut = BranchTargetIn;

  assign mem.mem_req   = req_c;
  assign mem.mem_we    = req_c & lat_we;
  assign mem.mem_addr  = lat_addr;
  assign mem.mem_wdata = lat_wdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_we    <= 1'b0;
      lat_rw    <= 1'b0;
      lat_m2r   <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_wreg  <= '0;
    end else if (state == IDLE && mem_op) begin
      lat_we    <= MemWriteIn;
      lat_rw    <= RegWriteIn;
      lat_m2r   <= MemtoRegIn;
      lat_addr  <= ALUResultIn;
      lat_wdata <= WriteDataIn;
      lat_wreg  <= WriteRegIn;
    end
  end

  // MEM/WB register: pass-through for non-memory ops, latched fields on completion,
  // bubble (RegWrite cleared, rest held) on every other edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      RegWriteOut  <= 1'b0;
      MemtoRegOut  <= 1'b0;
      ReadDataOut  <= '0;
      ALUResultOut <= '0;
      WriteRegOut  <= '0;
    end else if (state == IDLE && !mem_op) begin
      RegWriteOut  <= RegWriteIn;
      MemtoRegOut  <= MemtoRegIn;
      ReadDataOut  <= '0;
      ALUResultOut <= ALUResultIn;
      WriteRegOut  <= WriteRegIn;
    end else if (done) begin
      RegWriteOut  <= lat_rw;
      MemtoRegOut  <= lat_m2r;
      ReadDataOut  <= lat_we ? '0 : mem.mem_rdata;
      ALUResultOut <= lat_addr;
      WriteRegOut  <= lat_wreg;
    end else begin
      RegWriteOut  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage: vector table for non-memory ops,
// hand-written sequences for load/store/back-to-back/reset/timeout.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWriteIn, MemtoRegIn, MemWriteIn, MemReadIn, BranchIn, ZeroIn;
  logic [31:0] ALUResultIn, WriteDataIn;
  logic [4:0]  WriteRegIn;
  logic [7:0]  BranchTargetIn;
  logic        stall, PCSrc, RegWriteOut, MemtoRegOut, mem_error;
  logic [7:0]  BranchTargetOut;
  logic [31:0] ReadDataOut, ALUResultOut;
  logic [4:0]  WriteRegOut;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_stage_if mif ();

  mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .RegWriteIn      (RegWriteIn),
    .MemtoRegIn      (MemtoRegIn),
    .MemWriteIn      (MemWriteIn),
    .MemReadIn       (MemReadIn),
    .BranchIn        (BranchIn),
    .ZeroIn          (ZeroIn),
    .ALUResultIn     (ALUResultIn),
    .WriteDataIn     (WriteDataIn),
    .WriteRegIn      (WriteRegIn),
    .BranchTargetIn  (BranchTargetIn),
    .mem             (mif),
    .stall           (stall),
    .PCSrc           (PCSrc),
    .BranchTargetOut (BranchTargetOut),
    .RegWriteOut     (RegWriteOut),
    .MemtoRegOut     (MemtoRegOut),
    .ReadDataOut     (ReadDataOut),
    .ALUResultOut    (ALUResultOut),
    .WriteRegOut     (WriteRegOut),
    .mem_error       (mem_error)
  );

  typedef struct {
    logic        rw, m2r, br, zero, ack;
    logic [31:0] alu;
    logic [4:0]  wreg;
    logic [7:0]  tgt;
    logic        exp_pcsrc;
    logic        exp_rw, exp_m2r;
    logic [31:0] exp_alu;
    logic [4:0]  exp_wreg;
    logic [7:0]  exp_tgt;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nop_inputs();
    RegWriteIn = 0; MemtoRegIn = 0; MemWriteIn = 0; MemReadIn = 0;
    BranchIn = 0; ZeroIn = 0; ALUResultIn = '0; WriteDataIn = '0;
    WriteRegIn = '0; BranchTargetIn = '0;
    mif.mem_ack = 0; mif.mem_rdata = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sc;
    //           rw m2r br z ack alu            wreg tgt    pc rw m2r alu            wreg tgt
    vecs[0] = '{1, 0, 0, 0, 0, 32'h0000_1234, 5'd7,  8'h00, 0, 1, 0, 32'h0000_1234, 5'd7,  8'h00};
    vecs[1] = '{0, 0, 1, 1, 0, 32'h0000_0000, 5'd0,  8'h2C, 1, 0, 0, 32'h0000_0000, 5'd0,  8'h2C};
    vecs[2] = '{0, 0, 1, 0, 0, 32'h0000_0000, 5'd0,  8'h2C, 0, 0, 0, 32'h0000_0000, 5'd0,  8'h2C};
    vecs[3] = '{0, 0, 0, 1, 0, 32'h0000_0003, 5'd2,  8'h55, 0, 0, 0, 32'h0000_0003, 5'd2,  8'h55};
    vecs[4] = '{1, 1, 0, 0, 1, 32'hFFFF_FFFF, 5'd31, 8'h10, 0, 1, 1, 32'hFFFF_FFFF, 5'd31, 8'h10};
    vecs[5] = '{0, 0, 0, 0, 0, 32'h0000_0000, 5'd0,  8'h00, 0, 0, 0, 32'h0000_0000, 5'd0,  8'h00};
    vecs[6] = '{1, 0, 1, 1, 0, 32'h8000_0001, 5'd1,  8'hFF, 1, 1, 0, 32'h8000_0001, 5'd1,  8'hFF};

    nop_inputs();
    reset = 1;
    MemReadIn = 1;
    #12;
    chk("reset_stall",     32'(stall), 0);
    chk("reset_mem_req",   32'(mif.mem_req), 0);
    chk("reset_regwrite",  32'(RegWriteOut), 0);
    chk("reset_readdata",  ReadDataOut, 0);
    chk("reset_alu",       ALUResultOut, 0);
    chk("reset_mem_error", 32'(mem_error), 0);
    MemReadIn = 0;
    @(negedge clk);
    reset = 0;
    tick();

    foreach (vecs[i]) begin
      RegWriteIn = vecs[i].rw; MemtoRegIn = vecs[i].m2r; BranchIn = vecs[i].br;
      ZeroIn = vecs[i].zero; mif.mem_ack = vecs[i].ack; mif.mem_rdata = 32'h5555_AAAA;
      ALUResultIn = vecs[i].alu; WriteRegIn = vecs[i].wreg; BranchTargetIn = vecs[i].tgt;
      #1;
      chk($sformatf("vec%0d_stall", i),   32'(stall), 0);
      chk($sformatf("vec%0d_mem_req", i), 32'(mif.mem_req), 0);
      chk($sformatf("vec%0d_pcsrc", i),   32'(PCSrc), 32'(vecs[i].exp_pcsrc));
      chk($sformatf("vec%0d_target", i),  32'(BranchTargetOut), 32'(vecs[i].exp_tgt));
      tick();
      chk($sformatf("vec%0d_regwrite", i), 32'(RegWriteOut), 32'(vecs[i].exp_rw));
      chk($sformatf("vec%0d_memtoreg", i), 32'(MemtoRegOut), 32'(vecs[i].exp_m2r));
      chk($sformatf("vec%0d_alu", i),      ALUResultOut, vecs[i].exp_alu);
      chk($sformatf("vec%0d_wreg", i),     32'(WriteRegOut), 32'(vecs[i].exp_wreg));
      chk($sformatf("vec%0d_readdata", i), ReadDataOut, 0);
    end

    // Load 0x40, ack 3 cycles after mem_req; branch during stall must be masked.
    nop_inputs();
    MemReadIn = 1; RegWriteIn = 1; MemtoRegIn = 1; ALUResultIn = 32'h40; WriteRegIn = 5;
    BranchIn = 1; ZeroIn = 1;
    #1;
    sc = 0;
    chk("ld_c0_stall",   32'(stall), 1);
    chk("ld_c0_mem_req", 32'(mif.mem_req), 0);
    chk("ld_c0_pcsrc",   32'(PCSrc), 0);
    if (stall) sc++;
    tick();
    chk("ld_bubble_regwrite", 32'(RegWriteOut), 0);
    chk("ld_hold_alu",        ALUResultOut, 32'h8000_0001);
    ALUResultIn = 32'h999;
    for (int k = 1; k <= 3; k++) begin
      chk($sformatf("ld_c%0d_mem_req", k), 32'(mif.mem_req), 1);
      chk($sformatf("ld_c%0d_addr", k),    mif.mem_addr, 32'h40);
      chk($sformatf("ld_c%0d_we", k),      32'(mif.mem_we), 0);
      chk($sformatf("ld_c%0d_stall", k),   32'(stall), 1);
      if (stall) sc++;
      tick();
    end
    ALUResultIn = 32'h40;
    mif.mem_ack = 1; mif.mem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("ld_ack_stall", 32'(stall), 0);
    chk("ld_ack_addr",  mif.mem_addr, 32'h40);
    if (stall) sc++;
    tick();
    chk("ld_stall_cycles", 32'(sc), 4);

    // Back-to-back: read+write instruction presented right after load completion.
    nop_inputs();
    MemReadIn = 1; MemWriteIn = 1; RegWriteIn = 1; ALUResultIn = 32'h10;
    WriteDataIn = 32'h55; WriteRegIn = 3;
    #1;
    chk("ld_readdata", ReadDataOut, 32'hDEAD_BEEF);
    chk("ld_memtoreg", 32'(MemtoRegOut), 1);
    chk("ld_regwrite", 32'(RegWriteOut), 1);
    chk("ld_wreg",     32'(WriteRegOut), 5);
    chk("ld_alu",      ALUResultOut, 32'h40);
    chk("rw_c0_stall", 32'(stall), 1);
    chk("rw_c0_req",   32'(mif.mem_req), 0);
    tick();
    mif.mem_ack = 1; mif.mem_rdata = 32'h1111;
    #1;
    chk("rw_we",        32'(mif.mem_we), 1);
    chk("rw_addr",      mif.mem_addr, 32'h10);
    chk("rw_wdata",     mif.mem_wdata, 32'h55);
    chk("rw_hold_read", ReadDataOut, 32'hDEAD_BEEF);
    chk("rw_bubble",    32'(RegWriteOut), 0);
    tick();

    // Store 0x80 <- 0xCAFE with immediate ack.
    nop_inputs();
    MemWriteIn = 1; ALUResultIn = 32'h80; WriteDataIn = 32'hCAFE;
    #1;
    chk("rw_readdata", ReadDataOut, 0);
    chk("rw_regwrite", 32'(RegWriteOut), 1);
    chk("rw_wreg",     32'(WriteRegOut), 3);
    chk("st_c0_stall", 32'(stall), 1);
    tick();
    mif.mem_ack = 1;
    #1;
    chk("st_req",   32'(mif.mem_req), 1);
    chk("st_we",    32'(mif.mem_we), 1);
    chk("st_wdata", mif.mem_wdata, 32'hCAFE);
    chk("st_addr",  mif.mem_addr, 32'h80);
    chk("st_stall", 32'(stall), 0);
    tick();
    nop_inputs();
    #1;
    chk("st_done_we",       32'(mif.mem_we), 0);
    chk("st_done_req",      32'(mif.mem_req), 0);
    chk("st_done_regwrite", 32'(RegWriteOut), 0);
    chk("st_done_alu",      ALUResultOut, 32'h80);

    // Reset asserted in the middle of an access.
    tick();
    MemReadIn = 1; RegWriteIn = 1; ALUResultIn = 32'h44; WriteRegIn = 9;
    tick();
    chk("rst_mid_req_before", 32'(mif.mem_req), 1);
    #2;
    reset = 1;
    #1;
    chk("rst_mid_req",   32'(mif.mem_req), 0);
    chk("rst_mid_stall", 32'(stall), 0);
    @(negedge clk);
    reset = 0;
    nop_inputs();
    mif.mem_ack = 1; mif.mem_rdata = 32'hBAD0_BAD0;
    tick();
    chk("rst_ack_ignored_req", 32'(mif.mem_req), 0);
    tick();
    chk("rst_ack_ignored_rd",  ReadDataOut, 0);
    chk("rst_ack_ignored_rw",  32'(RegWriteOut), 0);
    chk("rst_ack_ignored_wr",  32'(WriteRegOut), 0);
    mif.mem_ack = 0;

    // No ack: abort after 4 ACCESS cycles when enabled, otherwise wait indefinitely.
    MemReadIn = 1; RegWriteIn = 1; ALUResultIn = 32'h60; WriteRegIn = 4;
    tick();
`ifdef MEM_TIMEOUT_EN
    for (int k = 1; k <= 3; k++) begin
      chk($sformatf("to_c%0d_stall", k), 32'(stall), 1);
      chk($sformatf("to_c%0d_err", k),   32'(mem_error), 0);
      tick();
    end
    chk("to_c4_stall", 32'(stall), 0);
    chk("to_c4_req",   32'(mif.mem_req), 1);
    nop_inputs();
    tick();
    chk("to_err_pulse", 32'(mem_error), 1);
    chk("to_regwrite",  32'(RegWriteOut), 0);
    chk("to_req",       32'(mif.mem_req), 0);
    chk("to_stall",     32'(stall), 0);
    tick();
    chk("to_err_clear", 32'(mem_error), 0);
`else
    for (int k = 1; k <= 6; k++) begin
      chk($sformatf("wait_c%0d_stall", k), 32'(stall), 1);
      chk($sformatf("wait_c%0d_err", k),   32'(mem_error), 0);
      tick();
    end
    mif.mem_ack = 1; mif.mem_rdata = 32'h0000_00AB;
    tick();
    nop_inputs();
    #1;
    chk("wait_readdata", ReadDataOut, 32'hAB);
    chk("wait_regwrite", 32'(RegWriteOut), 1);
    chk("wait_wreg",     32'(WriteRegOut), 4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
